// File: rtl/burst_sum_pkg.sv
// Shared types and constants for the burst sum accumulator and its
// carry-select adder.
package burst_sum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BLK_W       = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int ACC_W_DEF   = 12;
  localparam int MAX_LEN_DEF = 15;
  localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/csa_add_n.sv
// Generic combinational carry-select adder built from BLK_W-bit blocks.
// N must be a multiple of BLK_W.
module csa_add_n
  import burst_sum_pkg::*;
#(
  parameter int N = ACC_W_DEF
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int NB = N / BLK_W;

  logic [NB:0] c;

  assign c[0] = cin;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    logic [BLK_W:0] s0;
    logic [BLK_W:0] s1;

    // Both candidate sums are formed up front; the rippling carry only selects.
    assign s0 = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]};
    assign s1 = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]}
              + (BLK_W+1)'(1);

    assign s[g*BLK_W +: BLK_W] = c[g] ? s1[BLK_W-1:0] : s0[BLK_W-1:0];
    assign c[g+1]              = c[g] ? s1[BLK_W]     : s0[BLK_W];
  end

  assign cout = c[NB];

endmodule

// File: rtl/burst_sum_accumulator.sv
// Sums valid/ready operand bursts through a carry-select adder and emits one
// result word (sum, beat count, sticky overflow) per burst.
module burst_sum_accumulator
  import burst_sum_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow
);

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [ACC_W-1:0]  operand;
  logic [ACC_W-1:0]  add_s;
  logic              add_co;
  logic [CNT_W-1:0]  count, cnt_nxt;
  logic              ovf, ovf_nxt;
  logic              ready_q;
  logic              accept;

  assign operand = ACC_W'(in_data);
  assign accept  = in_valid && ready_q;

  csa_add_n #(.N(ACC_W)) u_add (
    .a    (acc),
    .b    (operand),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = count;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = operand;
          cnt_nxt   = CNT_W'(1);
          ovf_nxt   = 1'b0;
          state_nxt = (in_last || MAX_LEN == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nxt   = add_s;
          cnt_nxt   = count + CNT_W'(1);
          ovf_nxt   = ovf | add_co;
          state_nxt = (in_last || cnt_nxt == CNT_W'(MAX_LEN)) ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == DONE);
    in_ready  = ready_q;
  end

  // in_ready is registered from the next state so it is low during reset
  // and never depends combinationally on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      ready_q      <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      count   <= cnt_nxt;
      ovf     <= ovf_nxt;
      ready_q <= (state_nxt != DONE);
      if (accept && state_nxt == DONE) begin
        out_sum      <= acc_nxt;
        out_count    <= cnt_nxt;
        out_overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_burst_sum_accumulator.sv
// Randomized and directed bench for burst_sum_accumulator, run against a
// 12-bit and an 8-bit accumulator sharing one input stream.
module tb_burst_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_overflow_a;
  logic [11:0] out_sum_a;
  logic [3:0]  out_count_a;
  logic        in_ready_b, out_valid_b, out_overflow_b;
  logic [7:0]  out_sum_b;
  logic [3:0]  out_count_b;

  int total = 0;
  int bad   = 0;
  int unsigned beats[$];

  always #5 clk = ~clk;

  burst_sum_accumulator #(.DATA_W(8), .ACC_W(12), .MAX_LEN(15), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
    .out_overflow(out_overflow_a)
  );

  burst_sum_accumulator #(.DATA_W(8), .ACC_W(8), .MAX_LEN(15), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
    .out_overflow(out_overflow_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Starts and ends on a falling edge; garbage is driven during idle gaps.
  task automatic send_beat(input logic [7:0] d, input logic l, input int gap);
    int  n;
    bit  term;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    while (!in_ready_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("ready_timeout", in_ready_a, 1);
    @(posedge clk);
    beats.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
    term = l || (beats.size() == 15);
    check("beat_out_valid_a", out_valid_a, term);
    check("beat_out_valid_b", out_valid_b, term);
    check("beat_in_ready", in_ready_a, !term);
  endtask

  // Called on the falling edge right after the terminating accept.
  task automatic finish_burst(input int hold);
    int unsigned sum;
    logic [11:0] e12;
    logic [7:0]  e8;
    logic [3:0]  ecnt;
    sum = 0;
    foreach (beats[i]) sum += beats[i];
    e12  = 12'(sum % 4096);
    e8   = 8'(sum % 256);
    ecnt = 4'(beats.size());
    check("valid_a", out_valid_a, 1);
    check("valid_b", out_valid_b, 1);
    check("sum_a", out_sum_a, e12);
    check("cnt_a", out_count_a, ecnt);
    check("ovf_a", out_overflow_a, sum >= 4096);
    check("sum_b", out_sum_b, e8);
    check("cnt_b", out_count_b, ecnt);
    check("ovf_b", out_overflow_b, sum >= 256);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid_a, 1);
      check("hold_ready", in_ready_a, 0);
      check("hold_sum_a", out_sum_a, e12);
      check("hold_cnt_a", out_count_a, ecnt);
      check("hold_sum_b", out_sum_b, e8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_valid_a", out_valid_a, 0);
    check("rel_valid_b", out_valid_b, 0);
    check("rel_ready", in_ready_a, 1);
    check("rel_keep_sum", out_sum_a, e12);
    beats.delete();
  endtask

  initial begin
    bit   force_end;
    int   n;
    logic [7:0] d;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_ready", in_ready_a, 0);
    check("rst_valid", out_valid_a, 0);
    check("rst_sum", out_sum_a, 0);
    check("rst_cnt", out_count_a, 0);
    check("rst_ovf", out_overflow_a, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_rel_ready", in_ready_a, 0);
    @(negedge clk);
    check("post_rst_ready", in_ready_a, 1);

    send_beat(8'h06, 1'b0, 0);
    send_beat(8'h06, 1'b1, 0);
    check("two_sum", out_sum_a, 12);
    check("two_cnt", out_count_a, 2);
    check("two_ovf", out_overflow_a, 0);
    finish_burst(1);

    send_beat(8'h0E, 1'b0, 0);
    send_beat(8'h07, 1'b0, 1);
    send_beat(8'h02, 1'b0, 0);
    send_beat(8'h09, 1'b1, 0);
    check("carry_sum", out_sum_a, 32);
    check("carry_cnt", out_count_a, 4);
    finish_burst(0);

    for (int i = 0; i < 15; i++) send_beat(8'hFF, 1'b0, 0);
    check("max_sum_a", out_sum_a, 3825);
    check("max_cnt", out_count_a, 15);
    check("max_ovf_a", out_overflow_a, 0);
    check("max_sum_b", out_sum_b, 8'hF1);
    check("max_ovf_b", out_overflow_b, 1);
    finish_burst(0);

    send_beat(8'h33, 1'b0, 0);
    send_beat(8'h44, 1'b1, 0);
    finish_burst(5);
    send_beat(8'hA5, 1'b1, 0);
    check("single_sum", out_sum_a, 12'h0A5);
    check("single_cnt", out_count_a, 1);
    finish_burst(0);

    send_beat(8'h10, 1'b0, 3);
    send_beat(8'h20, 1'b0, 4);
    send_beat(8'h30, 1'b1, 2);
    check("gap_sum", out_sum_a, 12'h060);
    finish_burst(0);

    for (int b = 0; b < 40; b++) begin
      force_end = ($urandom_range(0, 4) == 0);
      n = force_end ? 15 : int'($urandom_range(1, 15));
      for (int i = 0; i < n; i++) begin
        d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        send_beat(d, (i == n - 1) && !force_end, int'($urandom_range(0, 2)));
      end
      finish_burst(int'($urandom_range(0, 3)));
    end

    send_beat(8'h40, 1'b0, 0);
    send_beat(8'h41, 1'b0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid_a, 0);
    check("mid_rst_ready", in_ready_a, 0);
    check("mid_rst_sum", out_sum_a, 0);
    check("mid_rst_cnt", out_count_a, 0);
    check("mid_rst_ovf", out_overflow_a, 0);
    @(negedge clk);
    rst = 1'b0;
    beats.delete();
    @(negedge clk);
    check("mid_rst_no_valid", out_valid_a, 0);
    send_beat(8'h02, 1'b0, 0);
    send_beat(8'h09, 1'b1, 0);
    check("after_rst_sum", out_sum_a, 11);
    check("after_rst_cnt", out_count_a, 2);
    finish_burst(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
